dec_alu_stage: RTL and testbench

Parametrised decode-to-ALU pipeline register with valid/ready handshaking, a two-entry skid buffer, and synchronous flush. It sits between the decoder/register-file read stage and the ALU. It carries the operand pair, immediate, ALU opcode and write-back controls. Unlike a plain flop stage, it absorbs downstream stalls without a combinational ready path and squashes in-flight instructions on branch/exception flush.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pipe_skid_slot.sv | 24 ++
 rtl/dec_alu_stage.sv | 135 +++++++++++++
 tb/tb_dec_alu_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode/ALU types: default widths, ALU opcodes
// and the decode-to-ALU payload bundle.
package cpu_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_ALU_OP_W   = 4;

  typedef enum logic [DEF_ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic                      we;
    logic [DEF_REG_ADDR_W-1:0] wb_addr;
    logic [DEF_DATA_W-1:0]     data1;
    logic [DEF_DATA_W-1:0]     data2;
    logic [DEF_DATA_W-1:0]     imm;
    logic [DEF_ALU_OP_W-1:0]   op;
  } dec_alu_payload_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// Generic payload register with synchronous clear and load.
// Ports: clk, i_clr (wins over load), i_ld, i_d -> o_q.
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_q <= '0;
    else if (i_ld)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/dec_alu_stage.sv
// Decode-to-ALU pipeline register, valid/ready, optional skid entry,
// synchronous flush. Ports: clk/rst/flush, in_* upstream, out_* to ALU.
module dec_alu_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ALU_OP_W   = DEF_ALU_OP_W,
  parameter bit SKID       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     dataReg1,
  input  logic [DATA_W-1:0]     dataReg2,
  input  logic [DATA_W-1:0]     immValueReg,
  input  logic [ALU_OP_W-1:0]   ALUop,
  input  logic                  writeEnableReg,
  input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     dataAlu1,
  output logic [DATA_W-1:0]     dataAlu2,
  output logic [DATA_W-1:0]     immValueAlu,
  output logic [ALU_OP_W-1:0]   op,
  output logic                  writeEnableAlu,
  output logic [REG_ADDR_W-1:0] writeBackAddrOut
);

  localparam int PW = 1 + REG_ADDR_W + 3*DATA_W + ALU_OP_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e        r_state;
  logic [PW-1:0] w_in_pl;
  logic [PW-1:0] w_main_d;
  logic [PW-1:0] w_main_q;
  logic [PW-1:0] w_skid_q;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_clr;
  logic          w_main_ld;
  logic          w_skid_ld;
  logic          w_we;

  assign w_in_pl = {writeEnableReg, writeBackAddrIn,
                    dataReg1, dataReg2, immValueReg, ALUop};

  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_clr      = rst | flush;

  // With the skid entry, ready is decoded from state only,
  // so out_ready never reaches in_ready combinationally.
  if (SKID) begin : g_rdy_skid
    assign in_ready = (r_state != S_TWO);
  end else begin : g_rdy_flop
    assign in_ready = out_ready | ~out_valid;
  end

  always_comb begin
    w_main_ld = 1'b0;
    w_skid_ld = 1'b0;
    w_main_d  = w_in_pl;
    unique case (r_state)
      S_EMPTY: w_main_ld = w_in_fire;
      S_ONE: begin
        if (w_in_fire && w_out_fire)
          w_main_ld = 1'b1;
        else if (w_in_fire && SKID)
          w_skid_ld = 1'b1;
      end
      S_TWO: begin
        if (w_out_fire) begin
          w_main_ld = 1'b1;
          w_main_d  = w_skid_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr)
      r_state <= S_EMPTY;
    else begin
      unique case (r_state)
        S_EMPTY:
          if (w_in_fire) r_state <= S_ONE;
        S_ONE: begin
          if (SKID && w_in_fire && !w_out_fire)
            r_state <= S_TWO;
          else if (!w_in_fire && w_out_fire)
            r_state <= S_EMPTY;
        end
        S_TWO:
          if (w_out_fire) r_state <= S_ONE;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  pipe_skid_slot #(.W(PW)) u_main (
    .clk   (clk),
    .i_clr (w_clr),
    .i_ld  (w_main_ld),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  if (SKID) begin : g_skid
    pipe_skid_slot #(.W(PW)) u_skid (
      .clk   (clk),
      .i_clr (w_clr),
      .i_ld  (w_skid_ld),
      .i_d   (w_in_pl),
      .o_q   (w_skid_q)
    );
  end else begin : g_noskid
    assign w_skid_q = '0;
  end

  assign {w_we, writeBackAddrOut, dataAlu1,
          dataAlu2, immValueAlu, op} = w_main_q;

  assign writeEnableAlu = w_we & out_valid;

endmodule

// File: tb/tb_dec_alu_stage.sv
// Bench for dec_alu_stage: SKID=1 instance against a queue model,
// plus a SKID=0 instance for the combinational-ready build.
module tb_dec_alu_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] dataReg1 = '0;
  logic [31:0] dataReg2 = '0;
  logic [31:0] immValueReg = '0;
  logic [3:0]  ALUop = '0;
  logic        writeEnableReg = 1'b0;
  logic [4:0]  writeBackAddrIn = '0;

  logic        in_ready, out_valid, writeEnableAlu;
  logic [31:0] dataAlu1, dataAlu2, immValueAlu;
  logic [3:0]  op;
  logic [4:0]  writeBackAddrOut;

  logic        in_valid0 = 1'b0;
  logic        out_ready0 = 1'b0;
  logic        in_ready0, out_valid0, writeEnableAlu0;
  logic [31:0] dataAlu1_0, dataAlu2_0, immValueAlu0;
  logic [3:0]  op0;
  logic [4:0]  writeBackAddrOut0;

  int tests = 0;
  int fails = 0;
  dec_alu_payload_t q[$];

  always #5 clk = ~clk;

  dec_alu_stage #(.SKID(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dataReg1(dataReg1), .dataReg2(dataReg2),
    .immValueReg(immValueReg), .ALUop(ALUop),
    .writeEnableReg(writeEnableReg),
    .writeBackAddrIn(writeBackAddrIn),
    .out_valid(out_valid), .out_ready(out_ready),
    .dataAlu1(dataAlu1), .dataAlu2(dataAlu2),
    .immValueAlu(immValueAlu), .op(op),
    .writeEnableAlu(writeEnableAlu),
    .writeBackAddrOut(writeBackAddrOut)
  );

  dec_alu_stage #(.SKID(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .dataReg1(dataReg1), .dataReg2(dataReg2),
    .immValueReg(immValueReg), .ALUop(ALUop),
    .writeEnableReg(writeEnableReg),
    .writeBackAddrIn(writeBackAddrIn),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .dataAlu1(dataAlu1_0), .dataAlu2(dataAlu2_0),
    .immValueAlu(immValueAlu0), .op(op0),
    .writeEnableAlu(writeEnableAlu0),
    .writeBackAddrOut(writeBackAddrOut0)
  );

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic dec_alu_payload_t mk(
    logic [31:0] d1, logic [31:0] d2, logic [31:0] im,
    logic [3:0] o, logic w, logic [4:0] a);
    dec_alu_payload_t p;
    p.we = w; p.wb_addr = a; p.data1 = d1;
    p.data2 = d2; p.imm = im; p.op = o;
    return p;
  endfunction

  function automatic dec_alu_payload_t got();
    return dec_alu_payload_t'({writeEnableAlu,
      writeBackAddrOut, dataAlu1, dataAlu2,
      immValueAlu, op});
  endfunction

  // One cycle: drive after negedge, check model, then
  // update the model with the transfers of this cycle.
  task automatic step(dec_alu_payload_t p, bit iv,
                      bit ordy, bit fl, bit rs);
    bit fin, fout;
    @(negedge clk);
    in_valid = iv; out_ready = ordy;
    flush = fl; rst = rs;
    dataReg1 = p.data1; dataReg2 = p.data2;
    immValueReg = p.imm; ALUop = p.op;
    writeEnableReg = p.we; writeBackAddrIn = p.wb_addr;
    #2;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0)
      chk("payload", got(), q[0]);
    else
      chk("we_idle", writeEnableAlu, 1'b0);
    fin  = iv && (q.size() < 2);
    fout = ordy && (q.size() != 0);
    if (fout) void'(q.pop_front());
    if (fl || rs) q.delete();
    else if (fin) q.push_back(p);
  endtask

  initial begin
    dec_alu_payload_t idle;
    idle = mk(0, 0, 0, 0, 0, 0);

    // reset held 2 cycles while upstream is valid
    in_valid = 1'b1; writeEnableReg = 1'b1;
    dataReg1 = 32'hdead;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_we", writeEnableAlu, 1'b0);
    chk("rst_payload", got(), idle);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_payload0", {writeEnableAlu0, out_valid0,
        dataAlu1_0, dataAlu2_0, immValueAlu0, op0,
        writeBackAddrOut0}, 0);

    // streaming, one per cycle
    for (int i = 0; i < 8; i++)
      step(mk(i, 32'h100 + i, 32'h50 + i, i[3:0], 1'b1,
              i[4:0]), 1, 1, 0, 0);
    step(idle, 0, 1, 0, 0);
    step(idle, 0, 1, 0, 0);

    // stall with skid: A, B, C back to back
    step(mk(32'hA, 1, 2, ALU_ADD, 1, 1), 1, 0, 0, 0);
    step(mk(32'hB, 3, 4, ALU_SUB, 1, 2), 1, 0, 0, 0);
    step(mk(32'hC, 5, 6, ALU_XOR, 0, 3), 1, 0, 0, 0);
    chk("stall_in_ready", in_ready, 1'b0);
    step(mk(32'hC, 5, 6, ALU_XOR, 0, 3), 1, 1, 0, 0);
    step(mk(32'hC, 5, 6, ALU_XOR, 0, 3), 1, 1, 0, 0);
    step(idle, 0, 1, 0, 0);
    step(idle, 0, 1, 0, 0);

    // flush while full, input D offered in the same cycle
    step(mk(32'hE, 7, 8, ALU_OR, 1, 4), 1, 0, 0, 0);
    step(mk(32'hF, 9, 10, ALU_AND, 1, 5), 1, 0, 0, 0);
    step(mk(32'hD, 11, 12, ALU_SLT, 1, 6), 1, 0, 1, 0);
    step(idle, 0, 1, 0, 0);
    chk("flush_payload", got(), idle);
    chk("flush_in_ready", in_ready, 1'b1);

    // SKID=0 instance: ready follows out_ready
    @(negedge clk);
    in_valid = 0; out_ready = 0; flush = 0;
    in_valid0 = 1; out_ready0 = 0;
    dataReg1 = 32'haa;
    #1 chk("s0_ready_empty", in_ready0, 1'b1);
    @(negedge clk);
    dataReg1 = 32'hbb;
    #1;
    chk("s0_valid", out_valid0, 1'b1);
    chk("s0_data_a", dataAlu1_0, 32'haa);
    chk("s0_ready_stall", in_ready0, 1'b0);
    out_ready0 = 1;
    #1 chk("s0_ready_comb", in_ready0, 1'b1);
    @(negedge clk);
    in_valid0 = 0;
    #1;
    chk("s0_data_b", dataAlu1_0, 32'hbb);
    chk("s0_valid_b", out_valid0, 1'b1);
    @(negedge clk);
    out_ready0 = 0;
    #1 chk("s0_drain", out_valid0, 1'b0);

    // random traffic with occasional flush/reset
    for (int n = 0; n < 10000; n++) begin
      dec_alu_payload_t p;
      p = mk($urandom, $urandom, $urandom,
             4'($urandom), 1'($urandom), 5'($urandom));
      step(p, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) == 0);
    end
    step(idle, 0, 1, 0, 0);
    step(idle, 0, 1, 0, 0);
    step(idle, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
